// File: rtl/tick_enable_gen.sv
// tick_enable_gen
// Derives a single-cycle clock-enable strobe from the system clock so that
// downstream LED logic stays on one clock net. The strobe period is a
// run-time programmable divisor. A new divisor is staged in a shadow
// register and only takes effect at a period boundary. Every output is
// registered.

module tick_enable_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int DIV_W       = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             heartbeat
);

  localparam int               DEF_DIV_INT = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [DIV_W-1:0] DEF_DIV     = DIV_W'(DEF_DIV_INT);

  // A default divisor below 2 cannot produce a one-cycle strobe, so refuse to elaborate
  generate
    if (DEF_DIV_INT < 2) begin : g_def_div_check
      $error("tick_enable_gen: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } mode_e;

  mode_e            mode;
  logic             wrap;
  logic             div_ok;

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [DIV_W-1:0] shadow, shadow_nxt;
  logic             pend, pend_nxt;
  logic             tick_nxt;
  logic [CNT_W-1:0] tick_cnt_nxt;
  logic             heartbeat_nxt;
  logic             div_ack_nxt;
  logic             div_err_nxt;

  // Next-state logic: period counting, wrap handling, then divisor load staging
  always_comb begin
    mode          = en ? RUN : HOLD;
    div_ok        = (div_val >= DIV_W'(2));
    wrap          = (mode == RUN) && (cnt == (div - DIV_W'(1)));

    cnt_nxt       = cnt;
    div_nxt       = div;
    shadow_nxt    = shadow;
    pend_nxt      = pend;
    tick_nxt      = 1'b0;
    tick_cnt_nxt  = tick_cnt;
    heartbeat_nxt = heartbeat;
    div_ack_nxt   = 1'b0;
    div_err_nxt   = 1'b0;

    case (mode)
      RUN: begin
        if (wrap) begin
          cnt_nxt       = '0;
          tick_nxt      = 1'b1;
          tick_cnt_nxt  = tick_cnt + CNT_W'(1);
          heartbeat_nxt = ~heartbeat;
          if (pend) begin
            div_nxt     = shadow;
            pend_nxt    = 1'b0;
            div_ack_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      HOLD: begin
        cnt_nxt = cnt;
      end
      default: begin
        cnt_nxt = cnt;
      end
    endcase

    // A load evaluated after the wrap so that a load on the wrap cycle stays pending
    if (div_load) begin
      if (div_ok) begin
        shadow_nxt = div_val;
        pend_nxt   = 1'b1;
      end else begin
        div_err_nxt = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset; reset drops any pending load
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div       <= DEF_DIV;
      shadow    <= '0;
      pend      <= 1'b0;
      tick      <= 1'b0;
      tick_cnt  <= '0;
      heartbeat <= 1'b0;
      div_ack   <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      div       <= div_nxt;
      shadow    <= shadow_nxt;
      pend      <= pend_nxt;
      tick      <= tick_nxt;
      tick_cnt  <= tick_cnt_nxt;
      heartbeat <= heartbeat_nxt;
      div_ack   <= div_ack_nxt;
      div_err   <= div_err_nxt;
    end
  end

endmodule
